// File: rtl/fsm_light_n.sv
// Button/auto-stepped position register driving a WIDTH-bit light bank in binary, bar or one-hot form.
// Latency: button to light 3 edges, auto step every AUTO_DIV cycles; no backpressure, inputs are never stalled.
module fsm_light_n #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          WRAP     = 1'b1,
  parameter int unsigned AUTO_DIV = 50_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [2:0]       i_button,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_light,
  output logic             o_auto
);

  localparam int unsigned PW = $clog2(AUTO_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(AUTO_DIV - 1);

  typedef enum logic {MANUAL, AUTO} state_t;

  state_t           state, state_nx;
  logic [2:0]       sync1, sync2, prev;
  logic [2:0]       rise;
  logic [WIDTH-1:0] pos, pos_nx;
  logic [WIDTH-1:0] max_pos, pos_inc, pos_dec;
  logic [1:0]       r_mode, r_mode_nx;
  logic             dir_up, dir_nx, step_up;
  logic [PW-1:0]    presc, presc_nx;

  assign rise = sync2 & ~prev;

  always_comb begin
    case (r_mode)
      2'b01:   max_pos = WIDTH'(WIDTH);
      2'b10:   max_pos = WIDTH'(WIDTH - 1);
      default: max_pos = '1;
    endcase
  end

  // Single-step helpers; with WRAP=0 they saturate at the ends.
  assign pos_inc = (pos == max_pos) ? (WRAP ? '0 : pos) : pos + WIDTH'(1);
  assign pos_dec = (pos == '0) ? (WRAP ? max_pos : pos) : pos - WIDTH'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      state  <= MANUAL;
      pos    <= '0;
      r_mode <= 2'b00;
      dir_up <= 1'b1;
      presc  <= '0;
    end else begin
      sync1  <= i_button;
      sync2  <= sync1;
      prev   <= sync2;
      state  <= state_nx;
      pos    <= pos_nx;
      r_mode <= r_mode_nx;
      dir_up <= dir_nx;
      presc  <= presc_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pos_nx    = pos;
    r_mode_nx = r_mode;
    dir_nx    = dir_up;
    presc_nx  = presc;
    step_up   = dir_up;
    if (i_mode != r_mode) begin
      r_mode_nx = i_mode;
      pos_nx    = '0;
      presc_nx  = '0;
    end else begin
      case (state)
        MANUAL: begin
          if (rise[2]) begin
            state_nx = AUTO;
            presc_nx = '0;
            dir_nx   = 1'b1;
          end else if (rise[0] && !rise[1]) begin
            pos_nx = pos_inc;
          end else if (rise[1] && !rise[0]) begin
            pos_nx = pos_dec;
          end
        end
        AUTO: begin
          if (rise[2]) begin
            state_nx = MANUAL;
            presc_nx = '0;
          end else begin
            // A direction press landing on a terminal count steers that same step.
            if (rise[0] && !rise[1]) begin
              step_up = 1'b1;
            end else if (rise[1] && !rise[0]) begin
              step_up = 1'b0;
            end
            dir_nx = step_up;
            if (presc == PRESC_LAST) begin
              presc_nx = '0;
              if (step_up) begin
                if (!WRAP && pos == max_pos) begin
                  dir_nx = 1'b0;
                  pos_nx = max_pos - WIDTH'(1);
                end else begin
                  pos_nx = pos_inc;
                end
              end else if (!WRAP && pos == '0) begin
                dir_nx = 1'b1;
                pos_nx = WIDTH'(1);
              end else begin
                pos_nx = pos_dec;
              end
            end else begin
              presc_nx = presc + PW'(1);
            end
          end
        end
        default: state_nx = MANUAL;
      endcase
    end
  end

  always_comb begin
    case (r_mode)
      2'b01:   o_light = ~({WIDTH{1'b1}} << pos);
      2'b10:   o_light = WIDTH'(1) << pos;
      default: o_light = pos;
    endcase
  end

  assign o_auto = (state == AUTO);

endmodule

// File: tb/tb_fsm_light_n.sv
// Bench for fsm_light_n: WRAP=1 and WRAP=0 instances share stimulus; explicit vectors plus random run vs a reference model.
module tb_fsm_light_n;

  localparam int W   = 4;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   btn;
  logic [1:0]   mode;
  logic [W-1:0] light_w, light_s;
  logic         auto_w, auto_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fsm_light_n #(.WIDTH(W), .WRAP(1'b1), .AUTO_DIV(DIV)) dut_w (
    .i_clk(clk), .i_reset(rst), .i_button(btn), .i_mode(mode),
    .o_light(light_w), .o_auto(auto_w));

  fsm_light_n #(.WIDTH(W), .WRAP(1'b0), .AUTO_DIV(DIV)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_button(btn), .i_mode(mode),
    .o_light(light_s), .o_auto(auto_s));

  typedef struct {
    int         pos;
    int         rmode;
    bit         autom;
    bit         dir_up;
    int         presc;
    logic [2:0] b1, b2, b3;
  } model_t;

  typedef struct {
    logic [2:0] btn;
    logic [1:0] mode;
    int         n_press;
    int         n_idle;
    int         exp_w;
    int         exp_s;
    bit         exp_auto;
  } vec_t;

  model_t mw, ms;
  vec_t   vt[$];

  function automatic model_t m_reset();
    model_t m;
    m.pos = 0; m.rmode = 0; m.autom = 0; m.dir_up = 1; m.presc = 0;
    m.b1 = '0; m.b2 = '0; m.b3 = '0;
    return m;
  endfunction

  function automatic int m_max(int rmode);
    case (rmode)
      1:       return W;
      2:       return W - 1;
      default: return (1 << W) - 1;
    endcase
  endfunction

  function automatic int m_light(model_t m);
    case (m.rmode)
      1:       return (1 << m.pos) - 1;
      2:       return 1 << m.pos;
      default: return m.pos;
    endcase
  endfunction

  // One clock edge: a press is seen when the sample two edges back is high and the one before it low.
  function automatic model_t m_step(model_t m, bit wrap, logic [2:0] b, logic [1:0] md);
    logic [2:0] r;
    int         mx, tgt;
    model_t     n;
    n = m;
    r = m.b2 & ~m.b3;
    n.b3 = m.b2; n.b2 = m.b1; n.b1 = b;
    mx = m_max(m.rmode);
    if (int'(md) != m.rmode) begin
      n.rmode = int'(md); n.pos = 0; n.presc = 0;
      return n;
    end
    if (r[2]) begin
      n.autom = !m.autom;
      n.presc = 0;
      if (!m.autom) n.dir_up = 1;
      return n;
    end
    if (!m.autom) begin
      if (r[0] && !r[1])
        n.pos = wrap ? (m.pos + 1) % (mx + 1) : (m.pos == mx ? mx : m.pos + 1);
      else if (r[1] && !r[0])
        n.pos = wrap ? (m.pos + mx) % (mx + 1) : (m.pos == 0 ? 0 : m.pos - 1);
      return n;
    end
    if (r[0] != r[1]) n.dir_up = r[0];
    n.presc = (m.presc + 1) % DIV;
    if (n.presc == 0) begin
      if (wrap) begin
        n.pos = n.dir_up ? (m.pos + 1) % (mx + 1) : (m.pos + mx) % (mx + 1);
      end else begin
        tgt = n.dir_up ? m.pos + 1 : m.pos - 1;
        if (tgt > mx) begin
          n.dir_up = 0; n.pos = mx - 1;
        end else if (tgt < 0) begin
          n.dir_up = 1; n.pos = 1;
        end else begin
          n.pos = tgt;
        end
      end
    end
    return n;
  endfunction

  function automatic vec_t mk(logic [2:0] b, logic [1:0] md, int np, int ni, int ew, int es, bit ea);
    vec_t v;
    v.btn = b; v.mode = md; v.n_press = np; v.n_idle = ni;
    v.exp_w = ew; v.exp_s = es; v.exp_auto = ea;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model_light_wrap", int'(light_w), m_light(mw));
    chk("model_auto_wrap", int'(auto_w), int'(mw.autom));
    chk("model_light_sat", int'(light_s), m_light(ms));
    chk("model_auto_sat", int'(auto_s), int'(ms.autom));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mw = m_reset();
      ms = m_reset();
    end else begin
      mw = m_step(mw, 1'b1, btn, mode);
      ms = m_step(ms, 1'b0, btn, mode);
    end
    #1;
    cmp_model();
  endtask

  initial begin
    rst = 1'b1; btn = '0; mode = 2'b00;
    mw = m_reset(); ms = m_reset();
    #1;
    chk("reset_light_wrap", int'(light_w), 0);
    chk("reset_auto_wrap", int'(auto_w), 0);
    chk("reset_light_sat", int'(light_s), 0);
    chk("reset_auto_sat", int'(auto_s), 0);
    repeat (3) tick();
    rst = 1'b0;

    // Binary steps and end behaviour
    vt.push_back(mk(3'b001, 2'b00, 10, 4, 1, 1, 0));
    vt.push_back(mk(3'b001, 2'b00, 10, 4, 2, 2, 0));
    vt.push_back(mk(3'b001, 2'b00, 10, 4, 3, 3, 0));
    vt.push_back(mk(3'b010, 2'b00, 10, 4, 2, 2, 0));
    vt.push_back(mk(3'b010, 2'b00, 10, 4, 1, 1, 0));
    vt.push_back(mk(3'b010, 2'b00, 10, 4, 0, 0, 0));
    vt.push_back(mk(3'b010, 2'b00, 10, 4, 15, 0, 0));
    vt.push_back(mk(3'b001, 2'b00, 10, 4, 0, 1, 0));
    // Bar mode
    vt.push_back(mk(3'b000, 2'b01, 1, 1, 0, 0, 0));
    vt.push_back(mk(3'b001, 2'b01, 10, 4, 1, 1, 0));
    vt.push_back(mk(3'b001, 2'b01, 10, 4, 3, 3, 0));
    vt.push_back(mk(3'b001, 2'b01, 10, 4, 7, 7, 0));
    vt.push_back(mk(3'b001, 2'b01, 10, 4, 15, 15, 0));
    vt.push_back(mk(3'b001, 2'b01, 10, 4, 0, 15, 0));
    // One-hot, simultaneous presses, auto run
    vt.push_back(mk(3'b000, 2'b10, 1, 1, 1, 1, 0));
    vt.push_back(mk(3'b011, 2'b10, 10, 4, 1, 1, 0));
    vt.push_back(mk(3'b001, 2'b10, 10, 4, 2, 2, 0));
    vt.push_back(mk(3'b101, 2'b10, 2, 1, 2, 2, 1));
    vt.push_back(mk(3'b000, 2'b10, 4, 0, 4, 4, 1));
    vt.push_back(mk(3'b000, 2'b10, 4, 0, 8, 8, 1));
    vt.push_back(mk(3'b000, 2'b10, 4, 0, 1, 4, 1));
    vt.push_back(mk(3'b000, 2'b10, 4, 0, 2, 2, 1));
    vt.push_back(mk(3'b010, 2'b10, 2, 2, 1, 1, 1));
    vt.push_back(mk(3'b000, 2'b10, 4, 0, 8, 2, 1));
    vt.push_back(mk(3'b100, 2'b10, 2, 1, 8, 2, 0));
    vt.push_back(mk(3'b000, 2'b10, 6, 0, 8, 2, 0));

    foreach (vt[i]) begin
      btn = vt[i].btn; mode = vt[i].mode;
      repeat (vt[i].n_press) tick();
      btn = '0;
      repeat (vt[i].n_idle) tick();
      chk($sformatf("vec%0d_light_wrap", i), int'(light_w), vt[i].exp_w);
      chk($sformatf("vec%0d_light_sat", i), int'(light_s), vt[i].exp_s);
      chk($sformatf("vec%0d_auto_wrap", i), int'(auto_w), int'(vt[i].exp_auto));
      chk($sformatf("vec%0d_auto_sat", i), int'(auto_s), int'(vt[i].exp_auto));
    end

    // Asynchronous reset in the middle of an auto prescale
    btn = 3'b100;
    repeat (2) tick();
    btn = '0;
    repeat (3) tick();
    chk("pre_reset_light", int'(light_w), 8);
    chk("pre_reset_auto", int'(auto_w), 1);
    #3;
    rst = 1'b1;
    mode = 2'b00;
    #1;
    chk("async_reset_light_wrap", int'(light_w), 0);
    chk("async_reset_auto_wrap", int'(auto_w), 0);
    chk("async_reset_light_sat", int'(light_s), 0);
    chk("async_reset_auto_sat", int'(auto_s), 0);
    repeat (2) tick();
    rst = 1'b0;
    btn = 3'b001;
    repeat (20) tick();
    chk("held_up_one_step_wrap", int'(light_w), 1);
    chk("held_up_one_step_sat", int'(light_s), 1);
    btn = '0;
    repeat (4) tick();

    // Random stimulus against the reference model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) btn[0] = ~btn[0];
      if ($urandom_range(0, 3) == 0) btn[1] = ~btn[1];
      if ($urandom_range(0, 15) == 0) btn[2] = ~btn[2];
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
